mmio_ram: RTL and testbench
===========================

Name: mmio_ram

Overview:
- Parametrised single-port data RAM for the game processor, with a configurable number of memory-mapped input-status words at the bottom of the address space.
- Each status word mirrors one synchronised game input (new-game, buttons, etc.) and holds a sticky rising-edge flag that the CPU clears by writing.
- After reset, a hardware sweep zeroes the whole array before the CPU may access it.
- Sits on the CPU data-memory bus and replaces the hard-wired single-flag RAM.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be at least 2.
- ADDRESS_WIDTH, 12, address bus width.
- DEPTH, 64, number of words, addresses 0..DEPTH-1; must be at most 2^ADDRESS_WIDTH.
- NUM_INPUTS, 4, number of status words, addresses 0..NUM_INPUTS-1; must satisfy 1 <= NUM_INPUTS < DEPTH.

Ports:
- clk, input, 1, system clock; all logic updates on its rising edge.
- reset_n, input, 1, synchronous active-low reset.
- wEn, input, 1, write enable; a cycle with wEn low is a read.
- addr, input, ADDRESS_WIDTH, word address.
- dataIn, input, DATA_WIDTH, write data.
- dataOut, output, DATA_WIDTH, registered read data.
- inputs, input, NUM_INPUTS, asynchronous game inputs; bit i maps to status word i.
- busy, output, 1, high while reset is asserted or the clear sweep is running; accesses are ignored while high.

Behaviour:
- One clock. Reset is synchronous and active-low.
- While reset_n = 0, at each edge:
  - state <= CLEAR, sweep pointer <= 0, dataOut <= 0, busy = 1.
  - All synchroniser, history and edge-flag flops <= 0.
- State machine:
  - CLEAR: writes 0 to MemoryArray[ptr] each cycle; ptr increments. At ptr = DEPTH-1, write it, then go to RUN.
  - The sweep takes exactly DEPTH cycles after reset release. busy falls on the edge that enters RUN.
  - RUN: normal operation. Only reset returns the block to CLEAR.
  - Reset asserted mid-sweep restarts the sweep from 0.
- Accesses while busy: wEn, addr and dataIn are ignored; dataOut holds 0.
- Reads (RUN, wEn = 0): dataOut <= word[addr] at the edge, so read latency is 1 cycle.
  - Status address i returns {zeros, edge_i, level_i}: bit0 = level, bit1 = sticky edge flag, upper bits 0.
  - addr >= DEPTH returns 0.
- Writes (RUN, wEn = 1):
  - Array address (NUM_INPUTS <= addr < DEPTH): stored; dataOut holds its previous value.
  - Status address i: only dataIn[1] = 1 has an effect, clearing edge_i (write-1-to-clear). The level bit and all other bits are not writable.
  - addr >= DEPTH: ignored.
  - There is no write-through; a read of a just-written address on the next cycle returns the new data.
- Input path, per bit i:
  - Two-flop synchroniser s1 -> s2, then history flop s3 <= s2.
  - level_i = s2.
  - Edge flag: edge_i set when s2 & ~s3 in RUN.
- Input timing: an input stable before edge k gives s1 at k and s2 at k+1.
  - A read sampled at edge k+2 or later returns the new level.
  - edge_i sets at k+2 and is readable from edge k+3.
- Edge detection is suppressed while busy, but s3 keeps tracking s2. An input held high across reset therefore produces no edge.
- A set and a W1C on the same edge: set wins, and edge_i stays 1.
- Status words are flops, not array storage. The array entries underneath them are never written and are not used.

Test Plan:
- Clear sweep: load nonzero data, pulse reset_n low 1 cycle, then release. Required: busy = 1 for exactly DEPTH cycles (64) after release, and every address reads 0 afterwards. A write attempted during busy is lost.
- Reset mid-sweep: assert reset_n at sweep cycle 30. Required: busy stays high for a full 64 cycles after the second release.
- Read/write: write 0xDEADBEEF to address 10, then read address 10. Required: dataOut = 0xDEADBEEF one edge after the read cycle. A read of address 70 returns 0, and a write to address 70 changes no word.
- Input edge: raise inputs[2] before edge k. Required: word 2 reads 0x1 via a read sampled at k+2 and 0x3 from k+3. After writing 0x2 to address 2, it reads 0x1. Lowering the input then gives 0x0.
- W1C race: time the address-1 write of 0x2 to the same edge that edge_1 sets. Required: word 1 then reads 0x3. Writing 0xFFFFFFFD to address 1 leaves edge_1 set.
- Input held high through reset: inputs[0] = 1 during and after reset. Required: word 0 reads 0x1 after busy falls, with no edge flag.

Source files
------------

// File: rtl/mmio_ram.sv
// mmio_ram: single-port data RAM for the game processor.
// The lowest NUM_INPUTS addresses are status words. Each one shows a synchronised
// game input level in bit 0 and a sticky rising-edge flag in bit 1. Writing a 1
// to bit 1 clears the flag. After reset, a hardware sweep zeroes the whole array.
// The CPU cannot access the RAM until the sweep has finished.
module mmio_ram #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int DEPTH         = 64,
    parameter int NUM_INPUTS    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wEn,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    output logic [DATA_WIDTH-1:0]    dataOut,
    input  logic [NUM_INPUTS-1:0]    inputs,
    output logic                     busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_L  = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] NUM_L    = (ADDRESS_WIDTH+1)'(NUM_INPUTS);
    localparam logic [PTR_W-1:0]       LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   dataOut_q, dataOut_d;
    logic [NUM_INPUTS-1:0]   s1_q, s2_q, s3_q, edge_q, edge_d;

    logic [ADDRESS_WIDTH:0]  addrExt;
    logic [PTR_W-1:0]        addrIdx;
    logic                    inStatus;
    logic                    inArray;
    logic                    running;
    logic [NUM_INPUTS-1:0]   hitMask;
    logic [NUM_INPUTS-1:0]   clrMask;
    logic [DATA_WIDTH-1:0]   statusWord;
    logic                    memWe;
    logic [PTR_W-1:0]        memWAddr;
    logic [DATA_WIDTH-1:0]   memWData;

    // Decode the address region. The extra top bit keeps the comparisons safe when DEPTH == 2**ADDRESS_WIDTH.
    assign addrExt  = {1'b0, addr};
    assign addrIdx  = addr[PTR_W-1:0];
    assign inStatus = addrExt < NUM_L;
    assign inArray  = !inStatus && (addrExt < DEPTH_L);
    assign running  = (state_q == RUN);
    assign busy     = !reset_n || !running;
    assign dataOut  = dataOut_q;

    // Sweep controller: walk the pointer once across the array, then settle in RUN.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == CLEAR) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (ptr_q == LAST_PTR) begin
                state_d = RUN;
                ptr_d   = '0;
            end
        end
    end

    // Sweep state and pointer registers. Reset always restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Status word read mux and edge-flag update. A new edge takes priority over a simultaneous clear.
    always_comb begin
        hitMask    = '0;
        statusWord = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            hitMask[i] = (addrExt == (ADDRESS_WIDTH+1)'(i));
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (hitMask[i]) begin
                statusWord[0] = s2_q[i];
                statusWord[1] = edge_q[i];
            end
        end
        clrMask = (running && wEn && dataIn[1]) ? hitMask : '0;
        edge_d  = running ? ((edge_q & ~clrMask) | (s2_q & ~s3_q)) : edge_q;
    end

    // Input synchroniser, history and sticky edge flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            edge_q <= '0;
        end else begin
            s1_q   <= inputs;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= edge_d;
        end
    end

    // Array write port: the sweep owns it while clearing, and the CPU owns it afterwards.
    always_comb begin
        memWe    = 1'b0;
        memWAddr = ptr_q;
        memWData = '0;
        if (state_q == CLEAR) begin
            memWe = 1'b1;
        end else if (wEn && inArray) begin
            memWe    = 1'b1;
            memWAddr = addrIdx;
            memWData = dataIn;
        end
    end

    // Array storage. It has no reset of its own; the sweep provides the clearing.
    always_ff @(posedge clk) begin
        if (reset_n && memWe) begin
            mem[memWAddr] <= memWData;
        end
    end

    // Registered read data. It is forced to 0 while busy and holds its value across writes.
    always_comb begin
        dataOut_d = dataOut_q;
        if (!running) begin
            dataOut_d = '0;
        end else if (!wEn) begin
            if (inStatus) begin
                dataOut_d = statusWord;
            end else if (inArray) begin
                dataOut_d = mem[addrIdx];
            end else begin
                dataOut_d = '0;
            end
        end
    end

    // Read data output register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dataOut_q <= '0;
        end else begin
            dataOut_q <= dataOut_d;
        end
    end

endmodule

// File: tb/tb_mmio_ram.sv
// tb_mmio_ram: scoreboard-driven bench for mmio_ram with default parameters.
// Inputs are driven 1 time unit after each rising edge, and dataOut is sampled at the same point.
module tb_mmio_ram;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 64;
    localparam int NIN   = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            wEn;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   dataIn;
    logic [DW-1:0]   dataOut;
    logic [NIN-1:0]  inputs;
    logic            busy;

    int              checks   = 0;
    int              failures = 0;
    logic [DW-1:0]   expQ[$];
    string           nameQ[$];
    logic [DW-1:0]   expVal;
    string           expName;

    mmio_ram #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .NUM_INPUTS(NIN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wEn(wEn), .addr(addr), .dataIn(dataIn),
        .dataOut(dataOut), .inputs(inputs), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a read and record the value dataOut must show after the next edge.
    task automatic driveRead(input int a, input logic [DW-1:0] exp, input string nm);
        wEn  = 1'b0;
        addr = AW'(a);
        expQ.push_back(exp);
        nameQ.push_back(nm);
    endtask

    // Drive a write and record the value dataOut must hold across it.
    task automatic driveWrite(input int a, input logic [DW-1:0] d, input logic [DW-1:0] holdExp, input string nm);
        wEn    = 1'b1;
        addr   = AW'(a);
        dataIn = d;
        expQ.push_back(holdExp);
        nameQ.push_back(nm);
    endtask

    // Count edges until busy falls, with a bounded budget.
    task automatic waitReady(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (busy && cnt < 200);
    endtask

    task automatic test_reset();
        int cnt;
        reset_n = 1'b0;
        wEn = 1'b0; addr = '0; dataIn = '0; inputs = '0;
        step();
        step();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_busy: busy=%b expected=1", busy); end
        checks++;
        if (dataOut !== '0) begin failures++; $display("[TB] FAIL reset_dataOut: dataOut=0x%08h expected=0x00000000", dataOut); end
        reset_n = 1'b1;
        waitReady(cnt);
        checks++;
        if (cnt != DEPTH) begin failures++; $display("[TB] FAIL reset_sweep_len: cycles=%0d expected=%0d", cnt, DEPTH); end
    endtask

    task automatic test_clear_sweep();
        int cnt;
        for (int a = NIN; a < DEPTH; a++) begin
            wEn = 1'b1; addr = AW'(a); dataIn = 32'h1000_0000 | DW'(a);
            step();
        end
        driveRead(5, 32'h1000_0005, "preload_5");
        step();
        expVal = expQ.pop_front(); expName = nameQ.pop_front();
        checks++;
        if (dataOut !== expVal) begin failures++; $display("[TB] FAIL %s: dataOut=0x%08h expected=0x%08h", expName, dataOut, expVal); end
        wEn = 1'b0;
        inputs[3] = 1'b1;
        repeat (5) step();
        inputs[3] = 1'b0;
        repeat (4) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        cnt = 0;
        do begin
            if (cnt == 0) driveWrite(20, 32'h0000_1234, '0, "busy_write_20");
            else if (cnt == 10) driveWrite(5, 32'h0000_CAFE, '0, "busy_write_5");
            else if (cnt == 11) driveRead(5, '0, "busy_read_5");
            else wEn = 1'b0;
            step();
            cnt++;
            if (expQ.size() > 0) begin
                expVal = expQ.pop_front(); expName = nameQ.pop_front();
                checks++;
                if (dataOut !== expVal) begin failures++; $display("[TB] FAIL %s: dataOut=0x%08h expected=0x%08h", expName, dataOut, expVal); end
            end
        end while (busy && cnt < 200);
        checks++;
        if (cnt != DEPTH) begin failures++; $display("[TB] FAIL sweep_len: cycles=%0d expected=%0d", cnt, DEPTH); end
        for (int a = 0; a < DEPTH; a++) begin
            driveRead(a, '0, $sformatf("cleared_%0d", a));
            step();
            expVal = expQ.pop_front(); expName = nameQ.pop_front();
            checks++;
            if (dataOut !== expVal) begin failures++; $display("[TB] FAIL %s: dataOut=0x%08h expected=0x%08h", expName, dataOut, expVal); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cnt;
        wEn = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (30) step();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_sweep_busy: busy=%b expected=1", busy); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        waitReady(cnt);
        checks++;
        if (cnt != DEPTH) begin failures++; $display("[TB] FAIL mid_sweep_len: cycles=%0d expected=%0d", cnt, DEPTH); end
    endtask

    task automatic test_read_write();
        driveWrite(12, 32'h0000_0055, '0, "wr12_hold");
        step();
        expVal = expQ.pop_front(); expName = nameQ.pop_front();
        checks++;
        if (dataOut !== expVal) begin failures++; $display("[TB] FAIL %s: dataOut=0x%08h expected=0x%08h", expName, dataOut, expVal); end
        for (int n = 0; n < 9; n++) begin
            case (n)
                0: driveRead(12, 32'h0000_0055, "rd12");
                1: driveWrite(10, 32'hDEAD_BEEF, 32'h0000_0055, "wr10_hold");
                2: driveRead(10, 32'hDEAD_BEEF, "rd10");
                3: driveRead(70, '0, "rd70_out_of_range");
                4: driveWrite(70, 32'hA5A5_A5A5, '0, "wr70_hold");
                5: driveRead(6, '0, "rd6_no_alias");
                6: driveRead(10, 32'hDEAD_BEEF, "rd10_after_wr70");
                7: driveWrite(63, 32'h0BAD_F00D, 32'hDEAD_BEEF, "wr63_hold");
                default: driveRead(63, 32'h0BAD_F00D, "rd63_top");
            endcase
            step();
            expVal = expQ.pop_front(); expName = nameQ.pop_front();
            checks++;
            if (dataOut !== expVal) begin failures++; $display("[TB] FAIL %s: dataOut=0x%08h expected=0x%08h", expName, dataOut, expVal); end
        end
    endtask

    task automatic test_input_edge();
        inputs[2] = 1'b1;
        for (int n = 0; n < 9; n++) begin
            case (n)
                0: driveRead(2, 32'h0, "edge_k");
                1: driveRead(2, 32'h0, "edge_k1");
                2: driveRead(2, 32'h1, "edge_k2_level");
                3: driveRead(2, 32'h3, "edge_k3_flag");
                4: driveWrite(2, 32'h2, 32'h3, "w1c_hold");
                5: begin driveRead(2, 32'h1, "after_w1c"); inputs[2] = 1'b0; end
                6: driveRead(2, 32'h1, "fall_k1");
                7: driveRead(2, 32'h0, "fall_k2");
                default: driveRead(2, 32'h0, "fall_steady");
            endcase
            step();
            expVal = expQ.pop_front(); expName = nameQ.pop_front();
            checks++;
            if (dataOut !== expVal) begin failures++; $display("[TB] FAIL %s: dataOut=0x%08h expected=0x%08h", expName, dataOut, expVal); end
        end
    endtask

    task automatic test_w1c_race();
        inputs[1] = 1'b1;
        for (int n = 0; n < 8; n++) begin
            case (n)
                0: driveRead(1, 32'h0, "race_k");
                1: driveRead(1, 32'h0, "race_k1");
                2: driveWrite(1, 32'h2, 32'h0, "race_w1c_hold");
                3: driveRead(1, 32'h3, "race_set_wins");
                4: driveWrite(1, 32'hFFFF_FFFD, 32'h3, "wr_fffffffd_hold");
                5: driveRead(1, 32'h3, "flag_kept");
                6: driveWrite(1, 32'h2, 32'h3, "clear_hold");
                default: driveRead(1, 32'h1, "flag_cleared");
            endcase
            step();
            expVal = expQ.pop_front(); expName = nameQ.pop_front();
            checks++;
            if (dataOut !== expVal) begin failures++; $display("[TB] FAIL %s: dataOut=0x%08h expected=0x%08h", expName, dataOut, expVal); end
        end
        inputs[1] = 1'b0;
        wEn = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_held_input();
        int cnt;
        inputs[0] = 1'b1;
        wEn = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL held_reset_busy: busy=%b expected=1", busy); end
        reset_n = 1'b1;
        waitReady(cnt);
        checks++;
        if (cnt != DEPTH) begin failures++; $display("[TB] FAIL held_sweep_len: cycles=%0d expected=%0d", cnt, DEPTH); end
        for (int n = 0; n < 3; n++) begin
            driveRead(0, 32'h1, $sformatf("held_word0_%0d", n));
            step();
            expVal = expQ.pop_front(); expName = nameQ.pop_front();
            checks++;
            if (dataOut !== expVal) begin failures++; $display("[TB] FAIL %s: dataOut=0x%08h expected=0x%08h", expName, dataOut, expVal); end
        end
        inputs[0] = 1'b0;
    endtask

    // Watchdog: stops a hung run with a failure report.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time=%0t limit reached", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        test_reset();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_read_write();
        test_input_edge();
        test_w1c_race();
        test_held_input();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
